ccff_chain_loader: RTL and testbench
====================================

// Module: ccff_chain_loader
// PURPOSE
//  Drives the configuration-chain (ccff) protocol from the programming side. Unpacks
//  bitstream words into serial bits on ccff_head, one bit per enabled prog_clk cycle.
//  Gates the chain clock via chain_en and collects ccff_tail from the chain's far end.
//  Sits between the bitstream fetch logic and the ccff_head of a chain of routing/IO tiles.
// PARAMETERS
//  CHAIN_LEN  5  total config bits in the driven chain (>=1)
//  WORD_W     8  bitstream word width (>=1)
//  CNT_W     16  width of internal bit counters; must satisfy 2**CNT_W > CHAIN_LEN
// PORTS
//  prog_clk      in   1       programming clock; all state on rising edge
//  prog_reset_n  in   1       asynchronous, active-low reset
//  start         in   1       pulse; begins a load when state is IDLE, ignored otherwise
//  bs_data       in   WORD_W  bitstream word; bit 0 is shifted first
//  bs_valid      in   1       bs_data valid
//  bs_ready      out  1       loader accepts bs_data this cycle
//  ccff_head     out  1       serial config bit into the chain
//  ccff_tail     in   1       serial bit out of the chain's last flop
//  chain_en      out  1       chain shifts on this prog_clk edge when 1
//  busy          out  1       state != IDLE
//  done          out  1       level; last load complete; cleared by next accepted start
//  error         out  1       level; readback mismatch (readback build only)
// BEHAVIOUR
//  Reset: state=IDLE, bs_ready=0, ccff_head=0, chain_en=0, busy=0, done=0, error=0.
//  Reset mid-load aborts at once; chain contents undefined; done stays 0.
//  States: IDLE -> LOAD on start. LOAD -> IDLE when CHAIN_LEN bits are shifted
//   (readback build: LOAD -> VERIFY -> IDLE).
//  Word buffer: one WORD_W register with a bits-left count.
//   bs_ready = LOAD && words_left>0 && bits_left<=1.
//   Word accepted on bs_valid&&bs_ready.
//  Shifting: chain_en=1 only in cycles where a buffered bit is presented; ccff_head = that bit.
//   Shift LSB first; words_left = ceil(CHAIN_LEN/WORD_W).
//   In the final word, bits above (CHAIN_LEN mod WORD_W) are discarded and never shifted.
//  Stall: buffer empty and bs_valid=0 -> chain_en=0, ccff_head holds, no bit lost or duplicated.
//  Throughput: word accepted in cycle t -> its bits on ccff_head in t+1..t+WORD_W.
//   Next word is accepted in the last of those cycles, giving 1 bit/cycle.
//   With bs_valid held high a load takes CHAIN_LEN+1 cycles from the first accept.
//  Completion: the cycle after the last shifted bit -> done=1, busy=0, chain_en=0.
//  start while busy: ignored. bs_valid outside LOAD: ignored, bs_ready=0.
//  Bits exit ccff_tail in insertion order, CHAIN_LEN enabled cycles after insertion.
// CONFIGURATION
//  CCFF_READBACK_EN defined:
//   - After LOAD, enter VERIFY for exactly CHAIN_LEN cycles with chain_en=1 and ccff_head=ccff_tail.
//     The chain recirculates and ends holding the same contents.
//   - CRC-8 (poly 0x07, init 0x00) is accumulated over bits shifted in LOAD and over ccff_tail in VERIFY.
//   - Exit VERIFY: done=1; error=1 iff the two CRCs differ. error clears on the next accepted start.
//  CCFF_READBACK_EN undefined:
//   - No VERIFY state, no CRC logic; error tied 0.
// TESTING
//  T1 CHAIN_LEN=5,WORD_W=8: start, bs_data=0x16 valid -> ccff_head 0,1,1,0,1 on 5 chain_en cycles;
//     bits 7:5 dropped; done=1 at cycle 6 after accept.
//  T2 CHAIN_LEN=20,WORD_W=8, words 0xA5,0x3C,0x0F, bs_valid always 1 -> exactly 3 accepts;
//     20 contiguous chain_en cycles; 20-bit chain model reads 0xF3CA5.
//  T3 same as T2 with bs_valid low 4 cycles before word 2 -> chain_en low exactly those 4 cycles;
//     chain model still 0xF3CA5.
//  T4 assert prog_reset_n=0 after 3 bits of T2 -> outputs at reset values immediately;
//     new start then loads correctly from bit 0.
//  T5 start pulsed during LOAD, bs_valid in IDLE -> no state change, bs_ready stays 0.
//  T6 (CCFF_READBACK_EN) good chain model -> error=0, chain unchanged.
//     Model bit 2 stuck-at-1 with 0x16 loaded -> error=1.

Source files
------------

// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: unpacks bitstream words LSB-first onto ccff_head and gates chain_en.
// Optional readback/CRC-8 verification is built when CCFF_READBACK_EN is defined.
module ccff_chain_loader #(
    parameter int unsigned CHAIN_LEN = 5,
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic [WORD_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              chain_en,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned N_WORDS   = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int unsigned LAST_BITS = CHAIN_LEN - (N_WORDS - 1) * WORD_W;

    typedef enum logic [1:0] {IDLE, LOAD, VERIFY} state_t;

    state_t              state_q, state_n;
    logic [WORD_W-1:0]   buf_q, buf_n;
    logic [CNT_W-1:0]    bits_left_q, bits_left_n;
    logic [CNT_W-1:0]    words_left_q, words_left_n;
    logic                head_q, head_n;
    logic                en_q, en_n;
    logic                ready_q, ready_n;
    logic                busy_q, busy_n;
    logic                done_q, done_n;
    logic                accept;

`ifdef CCFF_READBACK_EN
    logic [7:0]          crc_load_q, crc_load_n;
    logic [7:0]          crc_tail_q, crc_tail_n;
    logic [CNT_W-1:0]    vcnt_q, vcnt_n;
    logic                error_q, error_n;

    // Serial CRC-8, polynomial x^8+x^2+x+1
    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        crc8_step = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction
`endif

    assign accept = bs_valid && ready_q;

    // Next-state and next-output logic
    always_comb begin
        state_n      = state_q;
        buf_n        = buf_q;
        bits_left_n  = bits_left_q;
        words_left_n = words_left_q;
        head_n       = head_q;
        en_n         = 1'b0;
        done_n       = done_q;
`ifdef CCFF_READBACK_EN
        crc_load_n   = crc_load_q;
        crc_tail_n   = crc_tail_q;
        vcnt_n       = vcnt_q;
        error_n      = error_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_n      = LOAD;
                    words_left_n = CNT_W'(N_WORDS);
                    bits_left_n  = '0;
                    done_n       = 1'b0;
`ifdef CCFF_READBACK_EN
                    crc_load_n   = 8'h00;
                    crc_tail_n   = 8'h00;
                    error_n      = 1'b0;
`endif
                end
            end
            LOAD: begin
`ifdef CCFF_READBACK_EN
                if (en_q) crc_load_n = crc8_step(crc_load_q, head_q);
`endif
                if (accept) begin
                    buf_n        = bs_data >> 1;
                    head_n       = bs_data[0];
                    en_n         = 1'b1;
                    bits_left_n  = (words_left_q == CNT_W'(1)) ? CNT_W'(LAST_BITS) : CNT_W'(WORD_W);
                    words_left_n = words_left_q - CNT_W'(1);
                end else if (bits_left_q > CNT_W'(1)) begin
                    buf_n       = buf_q >> 1;
                    head_n      = buf_q[0];
                    en_n        = 1'b1;
                    bits_left_n = bits_left_q - CNT_W'(1);
                end else if (bits_left_q == CNT_W'(1)) begin
                    bits_left_n = '0;
                    // Last bit of the whole chain is being shifted this cycle
                    if (words_left_q == '0) begin
`ifdef CCFF_READBACK_EN
                        state_n = VERIFY;
                        en_n    = 1'b1;
                        vcnt_n  = CNT_W'(CHAIN_LEN - 1);
`else
                        state_n = IDLE;
                        done_n  = 1'b1;
`endif
                    end
                end
            end
`ifdef CCFF_READBACK_EN
            VERIFY: begin
                crc_tail_n = crc8_step(crc_tail_q, ccff_tail);
                if (vcnt_q == '0) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    error_n = (crc_tail_n != crc_load_q);
                end else begin
                    vcnt_n = vcnt_q - CNT_W'(1);
                    en_n   = 1'b1;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
        ready_n = (state_n == LOAD) && (words_left_n != '0) && (bits_left_n <= CNT_W'(1));
        busy_n  = (state_n != IDLE);
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q      <= IDLE;
            buf_q        <= '0;
            bits_left_q  <= '0;
            words_left_q <= '0;
            head_q       <= 1'b0;
            en_q         <= 1'b0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef CCFF_READBACK_EN
            crc_load_q   <= '0;
            crc_tail_q   <= '0;
            vcnt_q       <= '0;
            error_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_n;
            buf_q        <= buf_n;
            bits_left_q  <= bits_left_n;
            words_left_q <= words_left_n;
            head_q       <= head_n;
            en_q         <= en_n;
            ready_q      <= ready_n;
            busy_q       <= busy_n;
            done_q       <= done_n;
`ifdef CCFF_READBACK_EN
            crc_load_q   <= crc_load_n;
            crc_tail_q   <= crc_tail_n;
            vcnt_q       <= vcnt_n;
            error_q      <= error_n;
`endif
        end
    end

    assign bs_ready = ready_q;
    assign chain_en = en_q;
    assign busy     = busy_q;
    assign done     = done_q;

`ifdef CCFF_READBACK_EN
    // During VERIFY the chain recirculates its own output
    assign ccff_head = (state_q == VERIFY) ? ccff_tail : head_q;
    assign error     = error_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign ccff_head   = head_q;
    assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a 5-bit and a 20-bit chain model, each checked by a head-bit scoreboard.
module tb_ccff_chain_loader;

`ifdef CCFF_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared = 0;
    int mismatched = 0;

    // Instance A: CHAIN_LEN=5
    logic       a_start = 0, a_valid = 0, a_ready, a_head, a_tail, a_en, a_busy, a_done, a_err;
    logic [7:0] a_data = 0;
    logic [4:0] a_chain = 0;
    logic       a_stuck = 0;
    logic       a_mon = 1;
    bit         qa[$];
    int         a_en_cnt = 0, a_en_first = -1, a_en_last = -1;
    bit         a_exp;

    // Instance B: CHAIN_LEN=20
    logic        b_start = 0, b_valid = 0, b_ready, b_head, b_tail, b_en, b_busy, b_done, b_err;
    logic [7:0]  b_data = 0;
    logic [19:0] b_chain = 0;
    bit          qb[$];
    int          b_en_cnt = 0, b_en_first = -1, b_en_last = -1;
    bit          b_exp;

    ccff_chain_loader #(.CHAIN_LEN(5), .WORD_W(8), .CNT_W(16)) u_dut_a (
        .prog_clk(clk), .prog_reset_n(rst_n), .start(a_start), .bs_data(a_data),
        .bs_valid(a_valid), .bs_ready(a_ready), .ccff_head(a_head), .ccff_tail(a_tail),
        .chain_en(a_en), .busy(a_busy), .done(a_done), .error(a_err));

    ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8), .CNT_W(16)) u_dut_b (
        .prog_clk(clk), .prog_reset_n(rst_n), .start(b_start), .bs_data(b_data),
        .bs_valid(b_valid), .bs_ready(b_ready), .ccff_head(b_head), .ccff_tail(b_tail),
        .chain_en(b_en), .busy(b_busy), .done(b_done), .error(b_err));

    // Chain models: head enters the MSB, tail is bit 0 (first bit in ends at bit 0)
    always @(posedge clk)
        if (a_en) a_chain <= a_stuck ? ({a_head, a_chain[4:1]} | 5'b00100) : {a_head, a_chain[4:1]};
    assign a_tail = a_chain[0];

    always @(posedge clk)
        if (b_en) b_chain <= {b_head, b_chain[19:1]};
    assign b_tail = b_chain[0];

    // Scoreboards: every enabled chain cycle must present the next expected bit
    always @(negedge clk) begin
        if (rst_n && a_en && a_mon) begin
            a_en_cnt++;
            if (a_en_first < 0) a_en_first = cyc;
            a_en_last = cyc;
            compared++;
            if (qa.size() == 0) begin
                $display("FAIL a_head_extra: chain_en=1 with no expected bit at cycle %0d", cyc);
                mismatched++;
            end else begin
                a_exp = qa.pop_front();
                if (a_head !== a_exp) begin
                    $display("FAIL a_head: got %b expected %b at cycle %0d", a_head, a_exp, cyc);
                    mismatched++;
                end
            end
        end
        if (rst_n && b_en) begin
            b_en_cnt++;
            if (b_en_first < 0) b_en_first = cyc;
            b_en_last = cyc;
            compared++;
            if (qb.size() == 0) begin
                $display("FAIL b_head_extra: chain_en=1 with no expected bit at cycle %0d", cyc);
                mismatched++;
            end else begin
                b_exp = qb.pop_front();
                if (b_head !== b_exp) begin
                    $display("FAIL b_head: got %b expected %b at cycle %0d", b_head, b_exp, cyc);
                    mismatched++;
                end
            end
        end
    end

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if ({a_ready, a_head, a_en, a_busy, a_done, a_err} !== 6'b0) begin
            $display("FAIL reset_a: outputs %b expected 000000", {a_ready, a_head, a_en, a_busy, a_done, a_err});
            mismatched++;
        end
        compared++;
        if ({b_ready, b_head, b_en, b_busy, b_done, b_err} !== 6'b0) begin
            $display("FAIL reset_b: outputs %b expected 000000", {b_ready, b_head, b_en, b_busy, b_done, b_err});
            mismatched++;
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        compared++;
        if ({a_ready, a_en, a_busy, a_done, b_ready, b_en, b_busy, b_done} !== 8'b0) begin
            $display("FAIL reset_release: outputs %b expected 00000000",
                     {a_ready, a_en, a_busy, a_done, b_ready, b_en, b_busy, b_done});
            mismatched++;
        end
    endtask

    // Single short word: 0x16 into a 5-bit chain, bits 7:5 must be dropped
    task automatic test_single_word();
        logic [7:0] d = 8'h16;
        int t_acc = -1, t_done = -1;
        qa.delete();
        a_en_cnt = 0; a_en_first = -1;
        @(posedge clk); #1 a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0; a_data = d; a_valid = 1'b1;
        for (int r = 0; r <= RB; r++)
            for (int i = 0; i < 5; i++) qa.push_back(d[i]);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_ready && a_valid) begin t_acc = cyc; break; end
        end
        compared++;
        if (t_acc < 0) begin
            $display("FAIL t1_accept: no accept within 20 cycles, expected one");
            mismatched++;
        end
        @(posedge clk); #1 a_valid = 1'b0; a_data = 8'hFF;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (a_done) begin t_done = cyc; break; end
        end
        compared++;
        if (t_done < 0 || t_done - t_acc != 6 + 5 * RB) begin
            $display("FAIL t1_done_latency: got %0d expected %0d", t_done - t_acc, 6 + 5 * RB);
            mismatched++;
        end
        compared++;
        if ({a_busy, a_en, a_ready, a_err} !== 4'b0) begin
            $display("FAIL t1_idle: busy/en/ready/error %b expected 0000", {a_busy, a_en, a_ready, a_err});
            mismatched++;
        end
        compared++;
        if (qa.size() != 0 || a_en_cnt != 5 * (1 + RB)) begin
            $display("FAIL t1_bit_count: shifted %0d left %0d expected %0d left 0",
                     a_en_cnt, qa.size(), 5 * (1 + RB));
            mismatched++;
        end
        compared++;
        if (a_chain !== 5'h16) begin
            $display("FAIL t1_chain: got %h expected 16", a_chain);
            mismatched++;
        end
    endtask

    // Full 20-bit load; optional 4-cycle source stall before the third word and a stray start pulse
    task automatic test_load_b(input string tag, input bit stall, input bit pulse);
        logic [23:0] wv = 24'h0F3CA5;
        int widx = 0, accepts = 0, stall_left = 0, t_first = -1, t_done = -1, n;
        bit acc, pulsed = 0;
        qb.delete();
        b_en_cnt = 0; b_en_first = -1; b_en_last = -1;
        @(posedge clk); #1 b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0; b_data = wv[7:0]; b_valid = 1'b1;
        for (int c = 0; c < 150 && t_done < 0; c++) begin
            @(negedge clk);
            #1;
            acc = b_ready && b_valid;
            if (b_done) t_done = cyc;
            if (stall_left > 0 && b_ready && !b_valid) stall_left--;
            if (acc) begin
                if (t_first < 0) t_first = cyc;
                accepts++;
                n = (widx == 2) ? 4 : 8;
                for (int k = 0; k < n; k++) qb.push_back(wv[widx * 8 + k]);
                widx++;
                if (widx == 3 && RB == 1)
                    for (int k = 0; k < 20; k++) qb.push_back(wv[k]);
            end
            @(posedge clk); #1;
            b_start = 1'b0;
            if (pulse && !pulsed && b_en_cnt >= 5) begin b_start = 1'b1; pulsed = 1; end
            if (acc) begin
                if (widx < 3) b_data = wv[widx * 8 +: 8];
                else b_valid = 1'b0;
                if (stall && widx == 2) begin b_valid = 1'b0; stall_left = 4; end
            end else if (stall_left == 0 && widx < 3 && !b_valid) begin
                b_valid = 1'b1;
            end
        end
        b_start = 1'b0;
        compared++;
        if (t_done < 0) begin
            $display("FAIL %s_timeout: done never rose within 150 cycles", tag);
            mismatched++;
        end
        compared++;
        if (accepts != 3) begin
            $display("FAIL %s_accepts: got %0d expected 3", tag, accepts);
            mismatched++;
        end
        compared++;
        if (t_done - t_first != 21 + 20 * RB + (stall ? 4 : 0)) begin
            $display("FAIL %s_latency: got %0d expected %0d", tag, t_done - t_first, 21 + 20 * RB + (stall ? 4 : 0));
            mismatched++;
        end
        compared++;
        if (b_en_cnt != 20 * (1 + RB) || b_en_last - b_en_first + 1 != b_en_cnt + (stall ? 4 : 0)) begin
            $display("FAIL %s_en_span: count %0d span %0d expected count %0d span %0d", tag, b_en_cnt,
                     b_en_last - b_en_first + 1, 20 * (1 + RB), 20 * (1 + RB) + (stall ? 4 : 0));
            mismatched++;
        end
        compared++;
        if (qb.size() != 0) begin
            $display("FAIL %s_bits_missing: %0d expected bits never shifted", tag, qb.size());
            mismatched++;
        end
        compared++;
        if (b_chain !== 20'hF3CA5 || b_busy !== 1'b0 || b_err !== 1'b0) begin
            $display("FAIL %s_chain: chain %h busy %b error %b expected F3CA5 0 0", tag, b_chain, b_busy, b_err);
            mismatched++;
        end
    endtask

    task automatic test_back_to_back();
        test_load_b("t2", 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        test_load_b("t3", 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_load();
        qb.delete();
        b_en_cnt = 0; b_en_first = -1;
        @(posedge clk); #1 b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0; b_data = 8'hA5; b_valid = 1'b1;
        qb.push_back(1'b1); qb.push_back(1'b0); qb.push_back(1'b1); qb.push_back(1'b0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); #1;
            if (b_en_cnt >= 3) break;
        end
        compared++;
        if (b_en_cnt != 3) begin
            $display("FAIL t4_progress: shifted %0d bits expected 3", b_en_cnt);
            mismatched++;
        end
        @(posedge clk); #1 rst_n = 1'b0; b_valid = 1'b0;
        #1;
        compared++;
        if ({b_ready, b_head, b_en, b_busy, b_done, b_err} !== 6'b0) begin
            $display("FAIL t4_reset_now: outputs %b expected 000000", {b_ready, b_head, b_en, b_busy, b_done, b_err});
            mismatched++;
        end
        qb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        compared++;
        if (b_done !== 1'b0 || b_busy !== 1'b0) begin
            $display("FAIL t4_after_reset: done %b busy %b expected 0 0", b_done, b_busy);
            mismatched++;
        end
        test_load_b("t4_reload", 1'b0, 1'b0);
    endtask

    // bs_valid while idle and start while loading must both be ignored
    task automatic test_ignore();
        @(posedge clk); #1 b_valid = 1'b1; b_data = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            compared++;
            if (b_ready !== 1'b0 || b_busy !== 1'b0 || b_en !== 1'b0 || b_done !== 1'b1) begin
                $display("FAIL t5_idle_valid: ready %b busy %b en %b done %b expected 0 0 0 1",
                         b_ready, b_busy, b_en, b_done);
                mismatched++;
            end
        end
        @(posedge clk); #1 b_valid = 1'b0;
        test_load_b("t5_start_in_load", 1'b0, 1'b1);
    endtask

`ifdef CCFF_READBACK_EN
    task automatic test_readback();
        int t_done;
        a_mon = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            a_stuck = (pass == 1);
            t_done = -1;
            @(posedge clk); #1 a_start = 1'b1;
            @(posedge clk); #1 a_start = 1'b0; a_data = 8'h16; a_valid = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (a_ready) break;
            end
            @(posedge clk); #1 a_valid = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (a_done) begin t_done = cyc; break; end
            end
            compared++;
            if (t_done < 0 || a_err !== (pass == 1)) begin
                $display("FAIL t6_error_pass%0d: done_cycle %0d error %b expected %b", pass, t_done, a_err, pass == 1);
                mismatched++;
            end
            if (pass == 0) begin
                compared++;
                if (a_chain !== 5'h16) begin
                    $display("FAIL t6_chain_kept: got %h expected 16", a_chain);
                    mismatched++;
                end
            end
        end
        a_stuck = 1'b0;
        a_mon = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_stall();
        test_reset_mid_load();
        test_ignore();
`ifdef CCFF_READBACK_EN
        test_readback();
`endif
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
